// File: rtl/fifo_split.sv
// fifo_split: word FIFO that emits each 16-bit word as two bytes, high byte first (FIFO_SPLIT_LSB_FIRST_EN swaps the order).
// Latency: a word written into an empty FIFO shows its first byte on data_out one cycle later.
// Backpressure: input_enable drops while DEPTH words are held; data_out/output_valid hold while output_enable is low.
module fifo_split #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        input_valid,
    output logic        input_enable,
    input  logic [15:0] data_in,
    output logic        output_valid,
    input  logic        output_enable,
    output logic [7:0]  data_out
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [15:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        byte_sel;
    logic        wr_evt;
    logic        out_evt;
    logic        load;
    logic [15:0] rd_word;
    logic [7:0]  first_byte;
    logic [7:0]  second_byte;
    logic [7:0]  next_byte;

    assign count        = wr_ptr - rd_ptr;
    assign input_enable = (count < FULL_CNT);
    assign wr_evt       = input_valid && input_enable;
    assign out_evt      = output_valid && output_enable;
    // The output register refills whenever it is empty or being drained and a word is held.
    assign load         = (!output_valid || output_enable) && (count != '0);
    assign rd_word      = mem[rd_ptr[AW-1:0]];

`ifdef FIFO_SPLIT_LSB_FIRST_EN
    assign first_byte  = rd_word[7:0];
    assign second_byte = rd_word[15:8];
`else
    assign first_byte  = rd_word[15:8];
    assign second_byte = rd_word[7:0];
`endif

    assign next_byte = byte_sel ? second_byte : first_byte;

    always_ff @(posedge clk) begin
        if (wr_evt) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            byte_sel     <= 1'b0;
            output_valid <= 1'b0;
            data_out     <= 8'h00;
        end else begin
            if (wr_evt) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                data_out     <= next_byte;
                output_valid <= 1'b1;
                byte_sel     <= ~byte_sel;
                // Word is freed once its second byte has moved into the output register.
                if (byte_sel) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end else if (out_evt) begin
                output_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fifo_split.md
FIFO_SPLIT -- requirements
Module: fifo_split

Interface
REQ-001 SHALL have parameter DEPTH, default 16, word-storage entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port input_valid  input  1  producer presents a word on data_in.
REQ-005 SHALL have port input_enable  output  1  block can accept a word.
REQ-006 SHALL have port data_in  input  16  write word.
REQ-007 SHALL have port output_valid  output  1  data_out holds a valid byte.
REQ-008 SHALL have port output_enable  input  1  consumer takes the byte.
REQ-009 SHALL have port data_out  output  8  read byte, registered.

Function
REQ-010 SHALL define input event = input_valid && input_enable, and output event = output_valid && output_enable, both sampled on the clk rising edge.
REQ-011 SHALL split each accepted 16-bit word into two bytes and deliver data_in[15:8] before data_in[7:0].
REQ-012 SHALL store words in a DEPTH x 16 array, using write/read word pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH.
REQ-013 SHALL compute word count = wr_ptr - rd_ptr, modulo 2*DEPTH.
REQ-014 SHALL drive input_enable combinationally as (count < DEPTH).
REQ-015 SHALL, when full, refuse a write even if a read occurs in the same cycle.
REQ-016 SHALL have a one-byte output register (data_out, output_valid) and a byte-select bit (0 = high byte next).
REQ-017 SHALL load the output register on a clock edge when (output_valid==0 || output event) and count>0: data_out <= selected byte of mem[rd_ptr], output_valid <= 1.
REQ-018 SHALL toggle the byte-select bit on every load.
REQ-019 SHALL increment rd_ptr when the low byte is loaded, which frees that word.
REQ-020 SHALL, on an output event with count==0, clear output_valid; data_out holds its value.
REQ-021 SHALL hold data_out and output_valid stable while output_valid==1 and output_enable==0.
REQ-022 SHALL, on a write into an empty FIFO at edge N, raise output_valid at edge N+1 with the high byte, which is 1-cycle latency.
REQ-023 SHALL allow a simultaneous input and output event, with pointers and count updated consistently and no byte lost or duplicated.
REQ-024 SHALL give sustained throughput of one byte per cycle out and one word per two cycles in.
REQ-025 SHALL treat the mem write as non-reset storage; its contents are undefined until written.

Reset
REQ-026 SHALL, on rstn low, immediately set wr_ptr=0, rd_ptr=0, byte-select=0, output_valid=0, data_out=8'h00, input_enable=1.
REQ-027 SHALL, on reset asserted mid-operation, discard all stored and partially-read words; no byte emerges after reset release.
REQ-028 SHALL leave reset synchronously on the first clk edge with rstn high.

Configuration
REQ-029 SHALL, with FIFO_SPLIT_LSB_FIRST_EN defined, deliver data_in[7:0] before data_in[15:8].
REQ-030 SHALL, without FIFO_SPLIT_LSB_FIRST_EN, use high-byte-first order per REQ-011; timing and all other behaviour are identical in both builds.

Verification
REQ-031 SHALL cover: reset, then one word 16'hA1B2 with output_enable=1 -> data_out 8'hA1 then 8'hB2 on consecutive cycles, then output_valid=0.
REQ-032 SHALL cover: output_enable=0, write 16 words -> input_enable=0 after the 16th; a 17th word is held off, and output_valid=1 with data_out=high byte of word 0.
REQ-033 SHALL cover: full FIFO, input_valid=1, output_enable pulsed for one cycle -> no write that cycle; input_enable rises only after the low byte of word 0 is loaded.
REQ-034 SHALL cover: 40 words 16'h0100+i streamed with continuous input_valid and output_enable -> 80 bytes in exact order across pointer wrap.
REQ-035 SHALL cover: rstn pulsed low after the high byte of 16'hC3D4 is output -> output_valid=0 immediately, and 8'hD4 never appears.
REQ-036 SHALL cover: the FIFO_SPLIT_LSB_FIRST_EN build with word 16'hA1B2 -> 8'hB2 then 8'hA1.
